// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception-type codes, ExcCode
// mapping, Status/Cause bit positions and reset values.
package cp0_pkg;

    typedef enum logic [4:0] {
        REG_BADVADDR = 5'd8,
        REG_COUNT    = 5'd9,
        REG_COMPARE  = 5'd11,
        REG_STATUS   = 5'd12,
        REG_CAUSE    = 5'd13,
        REG_EPC      = 5'd14,
        REG_PRID     = 5'd15,
        REG_CONFIG   = 5'd16
    } cp0_reg_e;

    // Exception-type codes as produced by the exception decoder
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic [4:0] {
        EXCCODE_INT  = 5'h00,
        EXCCODE_ADEL = 5'h04,
        EXCCODE_ADES = 5'h05,
        EXCCODE_SYS  = 5'h08,
        EXCCODE_BP   = 5'h09,
        EXCCODE_RI   = 5'h0a,
        EXCCODE_OV   = 5'h0c,
        EXCCODE_TRAP = 5'h0d
    } exccode_e;

    localparam int unsigned STATUS_IE     = 0;
    localparam int unsigned STATUS_EXL    = 1;
    localparam int unsigned CAUSE_EXC_LO  = 2;
    localparam int unsigned CAUSE_EXC_HI  = 6;
    localparam int unsigned CAUSE_IPSW_LO = 8;
    localparam int unsigned CAUSE_IPSW_HI = 9;
    localparam int unsigned CAUSE_IPHW_LO = 10;
    localparam int unsigned CAUSE_IPHW_HI = 15;
    localparam int unsigned CAUSE_BD      = 31;

    // IM[15:8], EXL, IE
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;
    localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;

    function automatic logic is_exception(input logic [31:0] et);
        case (et)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
            EXC_BP, EXC_RI, EXC_OV, EXC_TRAP: is_exception = 1'b1;
            default:                          is_exception = 1'b0;
        endcase
    endfunction

    function automatic exccode_e exccode_of(input logic [31:0] et);
        case (et)
            EXC_ADEL: exccode_of = EXCCODE_ADEL;
            EXC_ADES: exccode_of = EXCCODE_ADES;
            EXC_SYS:  exccode_of = EXCCODE_SYS;
            EXC_BP:   exccode_of = EXCCODE_BP;
            EXC_RI:   exccode_of = EXCCODE_RI;
            EXC_OV:   exccode_of = EXCCODE_OV;
            EXC_TRAP: exccode_of = EXCCODE_TRAP;
            default:  exccode_of = EXCCODE_INT;
        endcase
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, timer_int_o
// latches on a nonzero Count==Compare match until Compare is rewritten.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic toggle;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_o     <= '0;
            compare_o   <= '0;
            toggle      <= 1'b0;
            timer_int_o <= 1'b0;
        end else begin
            if (count_we) begin
                count_o <= data_i;
                toggle  <= 1'b0;
            end else begin
                toggle <= ~toggle;
                if (toggle) count_o <= count_o + 32'd1;
            end

            // A Compare write clears the pending interrupt and beats a same-cycle match
            if (compare_we) begin
                compare_o   <= data_i;
                timer_int_o <= 1'b0;
            end else if (count_o == compare_o && compare_o != '0) begin
                timer_int_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status/Cause/EPC/BadVAddr, MTC0/MFC0 access.
// Count/Compare timer is present only when CP0_TIMER_EN is defined.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h004c_0102
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic exc_take;
    logic eret;
    logic mtc0;
    logic ip7;

    assign exc_take = is_exception(excepttype_i);
    assign eret     = (excepttype_i == EXC_ERET);
    assign mtc0     = we_i && !exc_take && !eret;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_we    (mtc0 && waddr_i == REG_COUNT),
        .compare_we  (mtc0 && waddr_i == REG_COMPARE),
        .data_i      (data_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .timer_int_o (timer_int_o)
    );
    assign ip7 = int_i[5] | timer_int_o;
`else
    assign count_o     = '0;
    assign compare_o   = '0;
    assign timer_int_o = 1'b0;
    assign ip7         = int_i[5];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            status_o   <= STATUS_RST;
            cause_o    <= '0;
            epc_o      <= '0;
            badvaddr_o <= '0;
        end else begin
            // Hardware IP bits follow the lines every cycle, independent of MTC0
            cause_o[CAUSE_IPHW_HI:CAUSE_IPHW_LO] <= {ip7, int_i[4:0]};

            if (exc_take) begin
                if (!status_o[STATUS_EXL]) begin
                    epc_o             <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
                    cause_o[CAUSE_BD] <= in_delayslot_i;
                end
                status_o[STATUS_EXL]              <= 1'b1;
                cause_o[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exccode_of(excepttype_i);
                if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES)
                    badvaddr_o <= bad_addr_i;
            end else if (eret) begin
                status_o[STATUS_EXL] <= 1'b0;
            end else if (mtc0) begin
                case (waddr_i)
                    REG_STATUS: status_o <= (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                    REG_CAUSE:  cause_o[CAUSE_IPSW_HI:CAUSE_IPSW_LO] <= data_i[CAUSE_IPSW_HI:CAUSE_IPSW_LO];
                    REG_EPC:    epc_o <= data_i;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_o;
            REG_COUNT:    data_o = count_o;
            REG_COMPARE:  data_o = compare_o;
            REG_STATUS:   data_o = status_o;
            REG_CAUSE:    data_o = cause_o;
            REG_EPC:      data_o = epc_o;
            REG_PRID:     data_o = PRID_VAL;
            REG_CONFIG:   data_o = CONFIG_VAL;
            default:      data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: vector table plus timer sequences
// (timer checks depend on CP0_TIMER_EN).
module tb_cp0_regfile;

    localparam logic [31:0] PRID = 32'h004c_0102;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic        timer_int_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    cp0_regfile #(.PRID_VAL(PRID)) dut (
        .clk            (clk),
        .rst            (rst),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .raddr_i        (raddr_i),
        .data_i         (data_i),
        .int_i          (int_i),
        .excepttype_i   (excepttype_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .bad_addr_i     (bad_addr_i),
        .data_o         (data_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .badvaddr_o     (badvaddr_o),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .timer_int_o    (timer_int_o)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [4:0]  raddr;
        logic [31:0] data;
        logic [5:0]  intr;
        logic [31:0] et;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [31:0] e_data;
        logic [31:0] e_status;
        logic [31:0] e_cause;
        logic [31:0] e_epc;
        logic [31:0] e_bad;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst = 1'b0; we_i = 1'b0; waddr_i = '0; data_i = '0; int_i = '0;
        excepttype_i = '0; pc_i = '0; in_delayslot_i = 1'b0; bad_addr_i = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        we_i = 1'b1; waddr_i = a; data_i = d;
        tick();
        we_i = 1'b0;
    endtask

    int unsigned cyc;

    initial begin
        //        rst   we    wa     ra     data          int    et     pc            ds    bad           e_data        e_status      e_cause       e_epc         e_bad
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  5'd12, 32'h0,        6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0040_0000, 32'h0040_0000, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  5'd13, 32'h0,        6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0,         32'h0040_0000, 32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0,  5'd15, 32'h0,        6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        PRID,          32'h0040_0000, 32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  5'd16, 32'h0,        6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0000_8000, 32'h0040_0000, 32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  5'd14, 32'h0,        6'h00, 32'h4, 32'hbfc0_0100, 1'b1, 32'h1,        32'hbfc0_00fc, 32'h0040_0002, 32'h8000_0010, 32'hbfc0_00fc, 32'h1};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  5'd13, 32'h0,        6'h00, 32'h8, 32'h0000_1234, 1'b0, 32'h0,        32'h8000_0020, 32'h0040_0002, 32'h8000_0020, 32'hbfc0_00fc, 32'h1};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  5'd12, 32'h0,        6'h00, 32'he, 32'h0,        1'b0, 32'h0,        32'h0040_0000, 32'h0040_0000, 32'h8000_0020, 32'hbfc0_00fc, 32'h1};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  5'd8,  32'h0,        6'h00, 32'h5, 32'h8000_1000, 1'b0, 32'hdead_beef, 32'hdead_beef, 32'h0040_0002, 32'h0000_0014, 32'h8000_1000, 32'hdead_beef};
        vecs[8]  = '{1'b0, 1'b1, 5'd12, 5'd12, 32'hffff_ffff, 6'h00, 32'he, 32'h0,        1'b0, 32'h0,        32'h0040_0000, 32'h0040_0000, 32'h0000_0014, 32'h8000_1000, 32'hdead_beef};
        vecs[9]  = '{1'b0, 1'b1, 5'd12, 5'd12, 32'hffff_ffff, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0040_ff03, 32'h0040_ff03, 32'h0000_0014, 32'h8000_1000, 32'hdead_beef};
        vecs[10] = '{1'b0, 1'b1, 5'd14, 5'd14, 32'h1234_5678, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h1234_5678, 32'h0040_ff03, 32'h0000_0014, 32'h1234_5678, 32'hdead_beef};
        vecs[11] = '{1'b0, 1'b1, 5'd8,  5'd8,  32'hffff_ffff, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'hdead_beef, 32'h0040_ff03, 32'h0000_0014, 32'h1234_5678, 32'hdead_beef};
        vecs[12] = '{1'b0, 1'b1, 5'd15, 5'd15, 32'h0,        6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        PRID,          32'h0040_ff03, 32'h0000_0014, 32'h1234_5678, 32'hdead_beef};
        vecs[13] = '{1'b0, 1'b1, 5'd13, 5'd13, 32'hffff_ffff, 6'h3f, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0000_ff14, 32'h0040_ff03, 32'h0000_ff14, 32'h1234_5678, 32'hdead_beef};
        vecs[14] = '{1'b0, 1'b0, 5'd0,  5'd13, 32'h0,        6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0000_0314, 32'h0040_ff03, 32'h0000_0314, 32'h1234_5678, 32'hdead_beef};
        vecs[15] = '{1'b0, 1'b0, 5'd0,  5'd14, 32'h0,        6'h00, 32'hc, 32'h0000_aaaa, 1'b1, 32'h0,        32'h1234_5678, 32'h0040_ff03, 32'h0000_0330, 32'h1234_5678, 32'hdead_beef};
        vecs[16] = '{1'b0, 1'b0, 5'd0,  5'd13, 32'h0,        6'h00, 32'h3, 32'h0000_5555, 1'b1, 32'h7,        32'h0000_0330, 32'h0040_ff03, 32'h0000_0330, 32'h1234_5678, 32'hdead_beef};
        vecs[17] = '{1'b1, 1'b1, 5'd14, 5'd12, 32'h5,        6'h3f, 32'h4, 32'h0000_0100, 1'b1, 32'h9,        32'h0040_0000, 32'h0040_0000, 32'h0,        32'h0,        32'h0};
        vecs[18] = '{1'b0, 1'b1, 5'd12, 5'd12, 32'hffff_ffff, 6'h00, 32'hc, 32'h0000_0100, 1'b0, 32'h0,        32'h0040_0002, 32'h0040_0002, 32'h0000_0030, 32'h0000_0100, 32'h0};
        vecs[19] = '{1'b1, 1'b0, 5'd0,  5'd0,  32'h0,        6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0,         32'h0040_0000, 32'h0,        32'h0,        32'h0};
        vecs[20] = '{1'b0, 1'b1, 5'd13, 5'd13, 32'hffff_ffff, 6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0000_0300, 32'h0040_0000, 32'h0000_0300, 32'h0,        32'h0};
        vecs[21] = '{1'b0, 1'b0, 5'd0,  5'd14, 32'h0,        6'h00, 32'h1, 32'h0,        1'b1, 32'h0,        32'hffff_fffc, 32'h0040_0002, 32'h8000_0300, 32'hffff_fffc, 32'h0};
        vecs[22] = '{1'b0, 1'b0, 5'd0,  5'd31, 32'h0,        6'h00, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0,         32'h0040_0002, 32'h8000_0300, 32'hffff_fffc, 32'h0};

        idle();
        raddr_i = '0;
        rst = 1'b1;
        tick();
        tick();

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; we_i = vecs[i].we; waddr_i = vecs[i].waddr;
            raddr_i = vecs[i].raddr; data_i = vecs[i].data; int_i = vecs[i].intr;
            excepttype_i = vecs[i].et; pc_i = vecs[i].pc; in_delayslot_i = vecs[i].ds;
            bad_addr_i = vecs[i].bad;
            tick();
            check($sformatf("v%0d data_o", i),     data_o,     vecs[i].e_data);
            check($sformatf("v%0d status_o", i),   status_o,   vecs[i].e_status);
            check($sformatf("v%0d cause_o", i),    cause_o,    vecs[i].e_cause);
            check($sformatf("v%0d epc_o", i),      epc_o,      vecs[i].e_epc);
            check($sformatf("v%0d badvaddr_o", i), badvaddr_o, vecs[i].e_bad);
        end

        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst timer_int_o", {31'b0, timer_int_o}, 32'h0);
        check("rst compare_o", compare_o, 32'h0);

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        check("count load", count_o, 32'h0);
        cyc = 0;
        while (!timer_int_o && cyc < 40) begin
            tick();
            cyc++;
        end
        check("timer rise latency", cyc, 32'd21);
        check("count at rise", count_o, 32'd10);
        tick();
        check("cause ip7 timer", {31'b0, cause_o[15]}, 32'h1);
        check("timer held", {31'b0, timer_int_o}, 32'h1);
        raddr_i = 5'd11;
        #0;
        check("mfc0 compare", data_o, 32'd10);
        mtc0(5'd11, 32'h100);
        check("timer cleared", {31'b0, timer_int_o}, 32'h0);
        check("compare written", compare_o, 32'h100);
        mtc0(5'd9, 32'hffff_ffff);
        tick();
        check("count pre-wrap", count_o, 32'hffff_ffff);
        tick();
        check("count wrap", count_o, 32'h0);
`else
        raddr_i = 5'd9;
        mtc0(5'd9, 32'd5);
        check("count ignored", count_o, 32'h0);
        check("mfc0 count", data_o, 32'h0);
        mtc0(5'd11, 32'd7);
        check("compare ignored", compare_o, 32'h0);
        tick();
        tick();
        check("timer tied", {31'b0, timer_int_o}, 32'h0);
        int_i = 6'h20;
        tick();
        check("cause ip7 ext", cause_o, 32'h0000_8000);
        int_i = 6'h00;
        tick();
        check("cause ip7 drop", cause_o, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS core. It is the consumer of the exception decoder's `exceptiontype` output: on every committed exception or ERET it updates Status, Cause, EPC and BadVAddr. It also services MTC0/MFC0 and runs the Count/Compare timer. The decoder reads `status_o`, `cause_o` and `epc_o` back in the same cycle to arbitrate the next exception.

## Interface
- `PRID_VAL`, default 32'h004c_0102: read-only processor ID value.
- `clk  in  1`: core clock, rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `we_i  in  1`: MTC0 write strobe.
- `waddr_i  in  5`: MTC0 register number.
- `raddr_i  in  5`: MFC0 register number.
- `data_i  in  32`: MTC0 write data.
- `int_i  in  6`: external hardware interrupt lines.
- `excepttype_i  in  32`: code from the exception decoder. 0 means none.
- `pc_i  in  32`: PC of the faulting instruction.
- `in_delayslot_i  in  1`: the faulting instruction is in a branch delay slot.
- `bad_addr_i  in  32`: faulting address for AdEL/AdES.
- `data_o  out  32`: MFC0 read data.
- `status_o`, `cause_o`, `epc_o`, `badvaddr_o`, `count_o`, `compare_o`  `out  32`: current register contents.
- `timer_int_o  out  1`: timer interrupt pending.

## Operation
- Registers, by CP0 number:
  - BadVAddr 8
  - Count 9
  - Compare 11
  - Status 12
  - Cause 13
  - EPC 14
  - PRId 15 (constant `PRID_VAL`)
  - Config 16 (constant 32'h0000_8000)
- Reset values:
  - Status 32'h0040_0000 (BEV=1).
  - All other state 0, including `timer_int_o`.
- MTC0 writable bits:
  - Status: IM[15:8], EXL[1], IE[0]. All other bits are preserved.
  - Cause: IP[9:8] only (software interrupts).
  - EPC, Count, Compare: all 32 bits.
  - BadVAddr, PRId, Config: the write is ignored.
- Cause.IP[15:10] is sampled every cycle from {`int_i[5]` | `timer_int_o`, `int_i[4:0]`}.
- Exception entry, for `excepttype_i` in {1,4,5,8,9,a,c,d}:
  - If Status.EXL=0:
    - EPC <= `in_delayslot_i` ? `pc_i`-4 : `pc_i`.
    - Cause.BD[31] <= `in_delayslot_i`.
  - If Status.EXL=1, EPC and BD are left unchanged.
  - Status.EXL <= 1.
  - Cause.ExcCode[6:2] gets:
    - 0x00 for code 1
    - 0x04 for code 4
    - 0x05 for code 5
    - 0x08 for code 8
    - 0x09 for code 9
    - 0x0a for code a
    - 0x0c for code c
    - 0x0d for code d
  - Codes 4 and 5 also load BadVAddr <= `bad_addr_i`.
- ERET (`excepttype_i`=32'he): Status.EXL <= 0. Nothing else changes.
- Any other nonzero code: no state change.
- Simultaneous events:
  - An exception or ERET in the same cycle as `we_i` discards the MTC0 write entirely.
  - An MTC0 to Cause in the same cycle as interrupt sampling: IP[15:10] takes the sampled value, IP[9:8] takes the write.
- Reads:
  - `data_o` is combinational from the registered contents selected by `raddr_i`.
  - There is no write-to-read bypass.
  - Unmapped numbers read 0.

## Timing
- All state updates occur on the rising edge.
- All outputs except `data_o` are registered.
- Count increments by 1 every second cycle:
  - An internal toggle bit, reset to 0, drives the increment.
  - Count wraps from 32'hffff_ffff to 0.
- MTC0 to Count loads `data_i` and clears the toggle.
- Timer interrupt:
  - When Count == Compare and Compare != 0, `timer_int_o` is set on the next edge.
  - It stays set until an MTC0 to Compare clears it on that write's edge.
  - A clear and a new match in the same cycle: the clear wins.
- Exception-to-visible latency: one cycle. EPC and Status.EXL are observable on the outputs the cycle after `excepttype_i` is asserted.
- A `rst` asserted mid-operation restores all reset values on the next edge, regardless of any other input.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count/Compare timer as described.
- `CP0_TIMER_EN` undefined:
  - Count and Compare read 0.
  - Writes to Count and Compare are ignored.
  - `timer_int_o` is tied 0.
  - Cause.IP7 is driven by `int_i[5]` alone.

## Structure
- Shared package `cp0_pkg`:
  - Register number constants.
  - Exception-type code constants (1, 4, 5, 8, 9, a, c, d, e), shared with the decoder.
  - ExcCode mapping.
  - Status/Cause bit-position constants.
  - Reset values.
- One sub-module, `cp0_timer`, owns:
  - Count, Compare, the toggle bit and `timer_int_o`.
  - It is instantiated only under `CP0_TIMER_EN`.

## Test plan
- Reset, then read regs 12, 13, 15, 16 -> 32'h0040_0000, 0, `PRID_VAL`, 32'h0000_8000.
- `excepttype_i`=4, `pc_i`=32'hbfc0_0100, `in_delayslot_i`=1, `bad_addr_i`=32'h1 -> EPC=32'hbfc0_00fc, BadVAddr=1, Cause=32'h8000_0010, Status.EXL=1.
- Raise exception 8 with EXL=1 -> EPC and BD unchanged, ExcCode=8. Then ERET -> EXL=0.
- MTC0 Compare=10, Count=0 -> `timer_int_o` rises when Count reaches 10 (about 20 cycles later) and Cause[15]=1. Then MTC0 Compare -> `timer_int_o`=0.
- MTC0 to Status with `data_i`=32'hffff_ffff in the same cycle as exception c -> write dropped, Status=32'h0040_0002, ExcCode=0x0c.
- MTC0 Cause=32'hffff_ffff with `int_i`=0 -> Cause=32'h0000_0300.
